// File: rtl/dd_pkg.sv
// Shared types, constants and parameter checks for the sequential double-dabble converter.
// Contents:
//   state_t       controller states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W   width of one packed BCD digit
//   dd_digits_ok  true when D decimal digits can hold every W-bit unsigned value
package dd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGIT_W = 4;

    // Checks 10**d > 2**w - 1 without overflowing: stops multiplying once the power of ten
    // already exceeds the largest binary value.
    function automatic bit dd_digits_ok(input int unsigned w, input int unsigned d);
        longint unsigned max_v;
        longint unsigned pow10;
        if (w == 0 || d == 0 || w > 62) begin
            return 1'b0;
        end
        max_v = (64'd1 << w) - 64'd1;
        pow10 = 64'd1;
        for (int unsigned i = 0; i < d; i++) begin
            if (pow10 > max_v) begin
                break;
            end
            pow10 = pow10 * 64'd10;
        end
        return pow10 > max_v;
    endfunction

endpackage

// File: rtl/dbl_dabble_seq_if.sv
// Handshake/data bundle between a requester and the sequential double-dabble converter.
// Signals:
//   start  requester -> converter  request conversion of b
//   b      requester -> converter  W-bit binary value
//   busy   converter -> requester  conversion in progress
//   done   converter -> requester  one-cycle pulse, bcd holds a new result
//   bcd    converter -> requester  D packed BCD digits, digit 0 = ones in bits [3:0]
interface dbl_dabble_seq_if #(
    parameter int unsigned W = 8,
    parameter int unsigned D = 3
);
    logic           start;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [4*D-1:0] bcd;

    modport master (
        output start,
        output b,
        input  busy,
        input  done,
        input  bcd
    );

    modport slave (
        input  start,
        input  b,
        output busy,
        output done,
        output bcd
    );
endinterface

// File: rtl/dd_adjust.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so that the following
// left shift carries correctly into the next decimal place.
// Ports:
//   digit_i  4-bit digit before correction
//   digit_o  4-bit digit after correction
module dd_adjust
    import dd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BCD_DIGIT_W'(5)) begin
            digit_o = digit_i + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/dbl_dabble_seq.sv
// Sequential double-dabble converter: turns a W-bit unsigned value into D packed BCD digits,
// one shift-and-adjust step per clock, with a start/busy/done handshake.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    slave side of dbl_dabble_seq_if (start, b in; busy, done, bcd out)
module dbl_dabble_seq
    import dd_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned D = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    dbl_dabble_seq_if.slave    bus
);

    localparam int unsigned BcdW = BCD_DIGIT_W * D;
    localparam int unsigned SrW  = BcdW + W;
    localparam int unsigned CntW = $clog2(W + 1);

    if (!dd_digits_ok(W, D)) begin : g_param_check
        $error("dbl_dabble_seq: D=%0d digits cannot hold every %0d-bit value", D, W);
    end

    state_t            state_q, state_d;
    logic [SrW-1:0]    sr_q, sr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;

    // Corrected shift register: digit fields adjusted, binary part passed through untouched.
    logic [SrW-1:0]    sr_adj;
    logic [SrW-1:0]    sr_shl;

    assign sr_adj[W-1:0] = sr_q[W-1:0];

    for (genvar i = 0; i < D; i++) begin : g_adjust
        dd_adjust u_adjust (
            .digit_i (sr_q  [W + BCD_DIGIT_W*i +: BCD_DIGIT_W]),
            .digit_o (sr_adj[W + BCD_DIGIT_W*i +: BCD_DIGIT_W])
        );
    end

    assign sr_shl = {sr_adj[SrW-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sr_d    = {{BcdW{1'b0}}, bus.b};
                    cnt_d   = CntW'(W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // start is deliberately not looked at here: requests while busy are dropped.
                sr_d  = sr_shl;
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    bcd_d   = sr_shl[SrW-1 -: BcdW];
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start) begin
                    sr_d    = {{BcdW{1'b0}}, bus.b};
                    cnt_d   = CntW'(W);
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
        end
    end

    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
    assign bus.bcd  = bcd_q;

endmodule
